core_seq_ctrl: RTL and testbench
================================

// Module: core_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the PRV32 core: fetch, execute, memory, write-back, trap.
//  Drives the exu state code (statu), owns the PC and handshakes both buses.
//  Waits on exu readiness for iterative shifts, and applies branch/jump results.
//  Sits between the decoder/exu and the SoC instruction/data buses.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset
//  TRAP_VEC     32'h0000_0100  PC loaded when a trap is taken
//  BUS_TIMEOUT  16             cycles without ack before a bus trap; 0 disables the timeout
// PORTS
//  clk          in   1   core clock; the single clock domain
//  rst          in   1   asynchronous, active-high reset
//  ibus_req     out  1   instruction fetch request; address is pc
//  ibus_ack     in   1   fetch data valid this cycle
//  ibus_err     in   1   fetch bus error
//  ir_we        out  1   latch instruction register
//  illegal      in   1   decoder: latched instruction is illegal
//  is_load      in   1   decoder: r8|r16|r32
//  is_store     in   1   decoder: w8|w16|w32
//  is_csr       in   1   decoder: any csrr* instruction
//  has_rd       in   1   decoder: instruction writes rd (rd!=0)
//  exu_rdy      in   1   exu rdy_exu
//  exu_jmp      in   1   exu registered jmp
//  exu_target   in   32  exu registered addr_csr_out (jump target)
//  statu        out  3   state code to the exu
//  pc           out  32  current instruction address
//  dbus_req     out  1   data access request; address is exu addr_csr_out
//  dbus_we      out  1   data access is a write
//  dbus_ack     in   1   data access complete
//  dbus_err     in   1   data bus error
//  rf_we        out  1   register file write strobe
//  csr_we       out  1   CSR write strobe
//  trap_we      out  1   write mepc<=pc and mcause<=trap_cause
//  trap_cause   out  2   0 illegal, 1 bus error, 2 misaligned target, 3 bus timeout
// BEHAVIOUR
//  States (statu encoding): IF=000, EX=001, MEM=010, WB=011, TRAP=100.
//  Reset values: statu=IF, pc=RESET_PC, trap_cause=0, timeout count=0; every strobe 0.
//  ibus_req/dbus_req are 1 in the IF and MEM states. They are asserted from the cycle
//    after the state is entered, and are not asserted during reset.
//  IF: ibus_req=1.
//    - ibus_err -> TRAP, cause 1.
//    - else ibus_ack -> ir_we=1 (same cycle, combinational), then EX.
//    - err and ack together: err wins, ir_we=0.
//  EX: statu=001.
//    - illegal sampled on the first EX cycle -> TRAP, cause 0.
//    - else wait for exu_rdy=1 at a clock edge; a shift holds EX for shamt cycles.
//    - exu_rdy high: load/store -> MEM, else -> WB.
//  MEM: dbus_req=1, dbus_we=is_store.
//    - dbus_err -> TRAP, cause 1.
//    - dbus_ack -> WB.
//  WB: one cycle, then IF. rf_we=has_rd & ~is_store. csr_we=is_csr.
//    - exu_jmp & exu_target[1] -> TRAP, cause 2; no rf_we/csr_we; pc unchanged.
//    - exu_jmp otherwise -> pc <= {exu_target[31:1],1'b0}.
//    - no jump -> pc <= pc+4; wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
//  TRAP: one cycle; trap_we=1, trap_cause valid, pc still the faulting PC.
//    - next edge: pc <= TRAP_VEC, statu -> IF.
//  Timeout:
//    - counter clears on every IF/MEM entry and counts each cycle without ack/err.
//    - at BUS_TIMEOUT-1 with no ack -> TRAP, cause 3.
//    - ack on that same cycle wins.
//  Reset mid-operation: immediate return to reset values; any pending bus request is dropped.
//  All strobes are single-cycle; no strobe is ever asserted outside its state.
// STRUCTURE
//  Shared package prv32_pkg: statu encodings (ST_IF..ST_TRAP), trap cause codes,
//    RESET_PC/TRAP_VEC defaults.
//  One sub-module, bus_wdt: loadable down-counter that outputs expired; instanced once,
//    shared by IF and MEM.
//  FSM, PC register and strobe decode stay in this module.
// TESTING
//  1. addi, ack on the first IF cycle: IF,EX,WB,IF (4 cycles).
//     rf_we in WB; pc 0->4. Then reset mid-EX -> statu=IF, pc=RESET_PC.
//  2. slli shamt=5: EX held 5 cycles until exu_rdy=1.
//     Exactly one rf_we; pc+4.
//  3. lw, dbus_ack after 3 wait cycles: MEM lasts 4 cycles with dbus_req=1, dbus_we=0.
//     sw: dbus_we=1, rf_we=0.
//  4. jalr, exu_target=32'h0000_0203 -> pc=32'h202.
//     exu_target=32'h0000_0206 -> TRAP cause 2, trap_we=1, pc=TRAP_VEC.
//  5. ibus_ack never arrives, BUS_TIMEOUT=16: TRAP cause 3 after 16 IF cycles.
//     ibus_err with ibus_ack together -> cause 1, ir_we=0.
//  6. illegal=1 in EX -> TRAP cause 0, mepc=faulting pc.
//     pc=32'hFFFF_FFFC non-jump -> pc wraps to 0.

Source files
------------

// File: rtl/prv32_pkg.sv
// Shared definitions for the PRV32 core sequencer: state codes driven to the exu,
// trap cause codes and default reset/trap addresses.
package prv32_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_EX   = 3'b001,
        ST_MEM  = 3'b010,
        ST_WB   = 3'b011,
        ST_TRAP = 3'b100
    } statu_t;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd0;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/bus_wdt.sv
// Bus watchdog: counts idle cycles of the current bus access and flags expiry
// on the LIMIT-th idle cycle. LIMIT=0 never expires.
module bus_wdt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// PRV32 multi-cycle sequencer: IF -> EX -> [MEM] -> WB, with a one-cycle TRAP state.
// Owns the PC, handshakes the instruction and data buses and drives statu to the exu.
module core_seq_ctrl
    import prv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC    = DEF_TRAP_VEC,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_req,
    input  logic        ibus_ack,
    input  logic        ibus_err,
    output logic        ir_we,
    input  logic        illegal,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_csr,
    input  logic        has_rd,
    input  logic        exu_rdy,
    input  logic        exu_jmp,
    input  logic [31:0] exu_target,
    output logic [2:0]  statu,
    output logic [31:0] pc,
    output logic        dbus_req,
    output logic        dbus_we,
    input  logic        dbus_ack,
    input  logic        dbus_err,
    output logic        rf_we,
    output logic        csr_we,
    output logic        trap_we,
    output logic [1:0]  trap_cause
);

    statu_t      state, next_state;
    logic [1:0]  cause_q, cause_d;
    logic        first_ex;
    logic [31:0] pc_q;
    logic        bad_target;
    logic        wdt_clear, wdt_tick, wdt_expired;

    // A jump to a target with bit 1 set cannot be fetched as a 32-bit word.
    assign bad_target = exu_jmp & exu_target[1];

    assign wdt_clear = (next_state != state) && (next_state == ST_IF || next_state == ST_MEM);
    assign wdt_tick  = ((state == ST_IF)  && !ibus_ack && !ibus_err) ||
                       ((state == ST_MEM) && !dbus_ack && !dbus_err);

    bus_wdt #(.LIMIT(BUS_TIMEOUT)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdt_clear),
        .tick    (wdt_tick),
        .expired (wdt_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IF;
            cause_q  <= CAUSE_ILLEGAL;
            first_ex <= 1'b0;
        end else begin
            state    <= next_state;
            cause_q  <= cause_d;
            first_ex <= (next_state == ST_EX) && (state != ST_EX);
        end
    end

    always_comb begin
        next_state = state;
        cause_d    = cause_q;
        case (state)
            ST_IF: begin
                if (ibus_err) begin
                    next_state = ST_TRAP;
                    cause_d    = CAUSE_BUS_ERR;
                end else if (ibus_ack) begin
                    next_state = ST_EX;
                end else if (wdt_expired) begin
                    next_state = ST_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            ST_EX: begin
                if (first_ex && illegal) begin
                    next_state = ST_TRAP;
                    cause_d    = CAUSE_ILLEGAL;
                end else if (exu_rdy) begin
                    next_state = (is_load || is_store) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                if (dbus_err) begin
                    next_state = ST_TRAP;
                    cause_d    = CAUSE_BUS_ERR;
                end else if (dbus_ack) begin
                    next_state = ST_WB;
                end else if (wdt_expired) begin
                    next_state = ST_TRAP;
                    cause_d    = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                if (bad_target) begin
                    next_state = ST_TRAP;
                    cause_d    = CAUSE_MISALIGN;
                end else begin
                    next_state = ST_IF;
                end
            end
            default: next_state = ST_IF;
        endcase
    end

    // Strobes are gated by rst so nothing fires while reset is held.
    always_comb begin
        ibus_req = 1'b0;
        ir_we    = 1'b0;
        dbus_req = 1'b0;
        dbus_we  = 1'b0;
        rf_we    = 1'b0;
        csr_we   = 1'b0;
        trap_we  = 1'b0;
        if (!rst) begin
            case (state)
                ST_IF: begin
                    ibus_req = 1'b1;
                    ir_we    = ibus_ack & ~ibus_err;
                end
                ST_MEM: begin
                    dbus_req = 1'b1;
                    dbus_we  = is_store;
                end
                ST_WB: begin
                    rf_we  = has_rd & ~is_store & ~bad_target;
                    csr_we = is_csr & ~bad_target;
                end
                ST_TRAP: trap_we = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (state == ST_TRAP) begin
            pc_q <= TRAP_VEC;
        end else if (state == ST_WB && !bad_target) begin
            pc_q <= exu_jmp ? {exu_target[31:1], 1'b0} : pc_q + 32'd4;
        end
    end

    assign pc         = pc_q;
    assign statu      = state;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: builds a per-cycle expected trace from instruction-level
// descriptions (phase lengths, bus responses, jumps) and compares it cycle by cycle.
module tb_core_seq_ctrl;

    localparam int          BT   = 16;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] TVEC = 32'h0000_0100;
    localparam int          EW   = 44;

    localparam logic [2:0] P_IF = 3'b000, P_EX = 3'b001, P_MEM = 3'b010, P_WB = 3'b011, P_TRAP = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        ibus_req, ibus_ack, ibus_err, ir_we;
    logic        illegal, is_load, is_store, is_csr, has_rd;
    logic        exu_rdy, exu_jmp;
    logic [31:0] exu_target;
    logic [2:0]  statu;
    logic [31:0] pc;
    logic        dbus_req, dbus_we, dbus_ack, dbus_err;
    logic        rf_we, csr_we, trap_we;
    logic [1:0]  trap_cause;

    always #5 clk = ~clk;

    core_seq_ctrl #(.RESET_PC(RPC), .TRAP_VEC(TVEC), .BUS_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_ack(ibus_ack), .ibus_err(ibus_err), .ir_we(ir_we),
        .illegal(illegal), .is_load(is_load), .is_store(is_store), .is_csr(is_csr), .has_rd(has_rd),
        .exu_rdy(exu_rdy), .exu_jmp(exu_jmp), .exu_target(exu_target),
        .statu(statu), .pc(pc),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
        .rf_we(rf_we), .csr_we(csr_we), .trap_we(trap_we), .trap_cause(trap_cause)
    );

    typedef struct packed {
        logic        ibus_ack, ibus_err, illegal, is_load, is_store, is_csr, has_rd, exu_rdy, exu_jmp;
        logic [31:0] exu_target;
        logic        dbus_ack, dbus_err;
    } stim_t;

    stim_t          stim_q[$];
    logic [EW-1:0]  exp_q[$];
    logic [31:0]    m_pc;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;

    task automatic check_val(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // {statu, ibus_req, ir_we, dbus_req, dbus_we, rf_we, csr_we, trap_we, cause-if-trap, pc}
    function automatic logic [EW-1:0] observed();
        return {statu, ibus_req, ir_we, dbus_req, dbus_we, rf_we, csr_we, trap_we,
                (trap_we ? trap_cause : 2'b00), pc};
    endfunction

    function automatic stim_t rand_stim(input bit ld, input bit st, input bit csr, input bit rd);
        stim_t s;
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        s = r[42:0];
        s.is_load  = ld;
        s.is_store = st;
        s.is_csr   = csr;
        s.has_rd   = rd;
        return s;
    endfunction

    function automatic void push_cyc(input stim_t s, input logic [2:0] ph, input logic [6:0] strb,
                                     input logic [1:0] cause);
        stim_q.push_back(s);
        exp_q.push_back({ph, strb, cause, m_pc});
    endfunction

    function automatic void take_trap(input logic [1:0] cause);
        push_cyc(rand_stim($urandom_range(0, 1), 1'b0, 1'b0, 1'b0), P_TRAP, 7'b0000001, cause);
        m_pc = TVEC;
    endfunction

    // One instruction: response cycle indices per phase, decode class, jump outcome.
    task automatic gen_instr(input int if_lat, input bit if_err, input bit ill, input int ex_lat,
                             input int kind, input int mem_lat, input bit mem_err,
                             input bit rd, input bit csr, input bit jmp, input logic [31:0] target,
                             input bit cut_ex);
        stim_t s;
        bit ld, st;
        ld = (kind == 1);
        st = (kind == 2);
        for (int c = 0; c < 100; c++) begin
            s = rand_stim(ld, st, csr, rd);
            s.ibus_ack = 1'b0;
            s.ibus_err = 1'b0;
            if (c == if_lat) begin
                s.ibus_ack = 1'b1;
                s.ibus_err = if_err;
                push_cyc(s, P_IF, {1'b1, ~if_err, 5'b00000}, 2'b00);
                if (if_err) begin
                    take_trap(2'd1);
                    return;
                end
                break;
            end
            push_cyc(s, P_IF, 7'b1000000, 2'b00);
            if (c == BT - 1) begin
                take_trap(2'd3);
                return;
            end
        end
        for (int c = 0; c < 100; c++) begin
            s = rand_stim(ld, st, csr, rd);
            s.exu_rdy = (c == ex_lat);
            if (c == 0) s.illegal = ill;
            push_cyc(s, P_EX, 7'b0000000, 2'b00);
            if (c == 0 && ill) begin
                take_trap(2'd0);
                return;
            end
            if (cut_ex && c == 1) return;
            if (c == ex_lat) break;
        end
        if (ld || st) begin
            for (int c = 0; c < 100; c++) begin
                s = rand_stim(ld, st, csr, rd);
                s.dbus_ack = 1'b0;
                s.dbus_err = 1'b0;
                if (c == mem_lat) begin
                    s.dbus_ack = 1'b1;
                    s.dbus_err = mem_err;
                    push_cyc(s, P_MEM, {2'b00, 1'b1, st, 3'b000}, 2'b00);
                    if (mem_err) begin
                        take_trap(2'd1);
                        return;
                    end
                    break;
                end
                push_cyc(s, P_MEM, {2'b00, 1'b1, st, 3'b000}, 2'b00);
                if (c == BT - 1) begin
                    take_trap(2'd3);
                    return;
                end
            end
        end
        s = rand_stim(ld, st, csr, rd);
        s.exu_jmp = jmp;
        if (jmp) s.exu_target = target;
        if (jmp && target[1]) begin
            push_cyc(s, P_WB, 7'b0000000, 2'b00);
            take_trap(2'd2);
            return;
        end
        push_cyc(s, P_WB, {4'b0000, rd & ~st, csr, 1'b0}, 2'b00);
        m_pc = jmp ? {target[31:1], 1'b0} : m_pc + 32'd4;
    endtask

    task automatic apply(input stim_t s);
        ibus_ack   = s.ibus_ack;
        ibus_err   = s.ibus_err;
        illegal    = s.illegal;
        is_load    = s.is_load;
        is_store   = s.is_store;
        is_csr     = s.is_csr;
        has_rd     = s.has_rd;
        exu_rdy    = s.exu_rdy;
        exu_jmp    = s.exu_jmp;
        exu_target = s.exu_target;
        dbus_ack   = s.dbus_ack;
        dbus_err   = s.dbus_err;
    endtask

    // Entered and left just after a rising edge.
    task automatic run_queue();
        stim_t s;
        logic [EW-1:0] e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            apply(s);
            @(negedge clk);
            cyc++;
            check_val($sformatf("cyc%0d", cyc), observed(), e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_check(input string tag);
        rst = 1'b1;
        apply(rand_stim(1'b0, 1'b0, 1'b1, 1'b1));
        ibus_ack = 1'b1;
        dbus_ack = 1'b1;
        #1;
        check_val(tag, observed(), {P_IF, 7'b0000000, 2'b00, RPC});
        check_val({tag, "_cause"}, {42'b0, trap_cause}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_pc = RPC;
    endtask

    initial begin
        logic [31:0] tgt;
        int kind;
        rst = 1'b1;
        apply('0);
        m_pc = RPC;
        @(posedge clk);
        #1;
        reset_check("por");

        // addi, then reset while held in EX
        gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(0, 0, 0, 5, 0, 0, 0, 1, 0, 0, 32'h0, 1);
        run_queue();
        reset_check("rst_mid_ex");

        // slli shamt=5
        gen_instr(0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        // lw with 3 wait cycles, sw
        gen_instr(1, 0, 0, 0, 1, 3, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(0, 0, 0, 1, 2, 2, 0, 1, 0, 0, 32'h0, 0);
        // jalr aligned and misaligned
        gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0203, 0);
        gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0000_0206, 0);
        // fetch timeout, ack on the last allowed cycle, err with ack
        gen_instr(99, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(BT - 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(2, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        // data timeout, data ack on last cycle, data error
        gen_instr(0, 0, 0, 0, 1, 99, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(0, 0, 0, 0, 1, BT - 1, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 32'h0, 0);
        // illegal, csr write, pc wrap
        gen_instr(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0);
        gen_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        run_queue();

        for (int i = 0; i < 120; i++) begin
            kind = $urandom_range(0, 2);
            tgt = $urandom();
            tgt[1] = ($urandom_range(0, 7) == 0);
            gen_instr(($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 3),
                      ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 14) == 0),
                      $urandom_range(0, 5),
                      kind,
                      ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 4),
                      ($urandom_range(0, 14) == 0),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      ($urandom_range(0, 3) == 0), tgt, 0);
            if (i == 60) begin
                run_queue();
                reset_check("rst_rand");
            end
        end
        run_queue();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
